// File: rtl/gyro_spi_sequencer.sv
// ---------------------------------------------------------------------------
// gyro_spi_sequencer
//
// Drives an 8-bit SPI byte engine to run a 3-axis gyro. After reset it writes
// CTRL_REG1 (0x20) and CTRL_REG4 (0x23), each in its own chip-select frame.
// It then burst-reads OUT_X_L..OUT_Z_H (0x28..0x2D) once per poll period and
// publishes signed 16-bit X/Y/Z samples together with a one-cycle strobe.
// The block owns slave-select framing, byte chaining and a per-byte watchdog.
//
// Parameters
//   CTRL_REG1_VAL    value written to 0x20
//   CTRL_REG4_VAL    value written to 0x23
//   SS_SETUP_CYCLES  cycles from SS low to the first begin pulse (>= 1)
//   SS_HOLD_CYCLES   cycles from the last end_transmission to SS high (>= 2)
//   POLL_CYCLES      cycles SS stays high after a read frame (>= 1)
//   TIMEOUT_CYCLES   cycles from a begin pulse to watchdog expiry (>= 2)
//
// Ports
//   clk                     system clock
//   rst                     asynchronous reset, active-low
//   enable                  level, sampled only between frames
//   spi_recieved_data       byte returned by the engine
//   spi_end_transmission    one-cycle byte-done pulse from the engine
//   spi_send_data           byte to the engine, stable from one SEND to the next
//   spi_begin_transmission  one-cycle start pulse to the engine
//   spi_slave_select        chip select, active-low
//   x_axis/y_axis/z_axis    last complete sample, {OUT_*_H, OUT_*_L}
//   data_valid              one-cycle pulse when x/y/z update together
//   cfg_done                both configuration writes done since reset/error
//   timeout_err             sticky watchdog flag, cleared only by reset
//   busy                    high whenever slave select is low
// ---------------------------------------------------------------------------
module gyro_spi_sequencer #(
  parameter logic [7:0]  CTRL_REG1_VAL   = 8'h0F,
  parameter logic [7:0]  CTRL_REG4_VAL   = 8'h30,
  parameter logic [15:0] SS_SETUP_CYCLES = 16'd100,
  parameter logic [15:0] SS_HOLD_CYCLES  = 16'd100,
  parameter logic [23:0] POLL_CYCLES     = 24'd1000000,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  spi_recieved_data,
  input  logic        spi_end_transmission,
  output logic [7:0]  spi_send_data,
  output logic        spi_begin_transmission,
  output logic        spi_slave_select,
  output logic [15:0] x_axis,
  output logic [15:0] y_axis,
  output logic [15:0] z_axis,
  output logic        data_valid,
  output logic        cfg_done,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, SS_SETUP, SEND, WAIT_DONE, SS_HOLD, POLL_WAIT
  } state_t;

  typedef enum logic [1:0] {
    TXN_REG1, TXN_REG4, TXN_READ
  } txn_t;

  // Terminal counts for the single shared 24-bit cycle counter.
  // The hold count ends one early because the cycle carrying the last
  // end_transmission is itself the first hold cycle. The watchdog ends two
  // early because the counter restarts in SEND, and the SEND cycle plus the
  // first WAIT_DONE cycle are both time elapsed since the begin pulse.
  localparam logic [23:0] SETUP_LAST = {8'h00, SS_SETUP_CYCLES} - 24'd1;
  localparam logic [23:0] HOLD_LAST  = {8'h00, SS_HOLD_CYCLES} - 24'd2;
  localparam logic [23:0] POLL_LAST  = POLL_CYCLES - 24'd1;
  localparam logic [23:0] WDOG_LAST  = TIMEOUT_CYCLES - 24'd2;

  // Byte table: config writes are {addr, value}; the read is the
  // read|auto-increment command for 0x28 followed by six dummy bytes.
  function automatic logic [7:0] tx_byte(input txn_t t, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (t)
      TXN_REG1: b = (idx == 3'd0) ? 8'h20 : CTRL_REG1_VAL;
      TXN_REG4: b = (idx == 3'd0) ? 8'h23 : CTRL_REG4_VAL;
      default:  b = (idx == 3'd0) ? 8'hE8 : 8'h00;
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  txn_t        txn_q, txn_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  last_idx;
  logic        ss_q, ss_d;
  logic        begin_q, begin_d;
  logic [7:0]  send_q, send_d;
  logic        cfg_done_q, cfg_done_d;
  logic        tmo_q, tmo_d;
  logic        dv_q, dv_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  // X_L, X_H, Y_L, Y_H, Z_L, Z_H as they arrive; published only at frame end
  // so a partially received frame is never visible on x/y/z.
  logic [7:0]  shadow_q [6];
  logic [7:0]  shadow_d [6];

  assign last_idx = (txn_q == TXN_READ) ? 3'd6 : 3'd1;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    cnt_d      = cnt_q + 24'd1;
    byte_idx_d = byte_idx_q;
    ss_d       = ss_q;
    cfg_done_d = cfg_done_q;
    tmo_d      = tmo_q;
    dv_d       = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    shadow_d   = shadow_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d    = SS_SETUP;
          ss_d       = 1'b0;
          byte_idx_d = 3'd0;
        end
      end

      SS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end

      SEND: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end

      WAIT_DONE: begin
        // A done pulse on the expiry cycle still counts as in time.
        if (spi_end_transmission) begin
          cnt_d = '0;
          if (txn_q == TXN_READ && byte_idx_q != 3'd0) begin
            shadow_d[byte_idx_q - 3'd1] = spi_recieved_data;
          end
          if (byte_idx_q == last_idx) begin
            state_d = SS_HOLD;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = SEND;
          end
        end else if (cnt_q == WDOG_LAST) begin
          // Abandon the frame and restart from the first config write.
          state_d    = POLL_WAIT;
          cnt_d      = '0;
          ss_d       = 1'b1;
          tmo_d      = 1'b1;
          cfg_done_d = 1'b0;
          txn_d      = TXN_REG1;
        end
      end

      SS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ss_d    = 1'b1;
          state_d = POLL_WAIT;
          cnt_d   = '0;
          if (txn_q == TXN_READ) begin
            x_d  = {shadow_q[1], shadow_q[0]};
            y_d  = {shadow_q[3], shadow_q[2]};
            z_d  = {shadow_q[5], shadow_q[4]};
            dv_d = 1'b1;
          end else begin
            if (txn_q == TXN_REG4) begin
              cfg_done_d = 1'b1;
            end
            txn_d = (txn_q == TXN_REG1) ? TXN_REG4 : TXN_READ;
            // Config frames skip the poll period: preloading the terminal
            // count leaves exactly one POLL_WAIT cycle.
            cnt_d = POLL_LAST;
          end
        end
      end

      POLL_WAIT: begin
        if (cnt_q == POLL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Byte and strobe are registered on the edge that enters SEND, so they
    // are valid exactly during the SEND cycle and the byte then holds.
    begin_d = (state_d == SEND);
    send_d  = (state_d == SEND) ? tx_byte(txn_d, byte_idx_d) : send_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      txn_q      <= TXN_REG1;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      ss_q       <= 1'b1;
      begin_q    <= 1'b0;
      send_q     <= 8'h00;
      cfg_done_q <= 1'b0;
      tmo_q      <= 1'b0;
      dv_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      // NOTE: the shadow bytes are six plain flops, not a RAM, so resetting
      // them costs nothing and keeps simulation free of X.
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      ss_q       <= ss_d;
      begin_q    <= begin_d;
      send_q     <= send_d;
      cfg_done_q <= cfg_done_d;
      tmo_q      <= tmo_d;
      dv_q       <= dv_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      shadow_q   <= shadow_d;
    end
  end

  assign spi_send_data          = send_q;
  assign spi_begin_transmission = begin_q;
  assign spi_slave_select       = ss_q;
  assign x_axis                 = x_q;
  assign y_axis                 = y_q;
  assign z_axis                 = z_q;
  assign data_valid             = dv_q;
  assign cfg_done               = cfg_done_q;
  assign timeout_err            = tmo_q;
  assign busy                   = ~ss_q;

endmodule

// File: tb/tb_gyro_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gyro_spi_sequencer
//
// Self-checking bench for gyro_spi_sequencer. An SPI engine model answers
// each begin pulse after a random byte time with a random response byte
// (or a planned one), or stays silent to provoke the watchdog. A frame
// monitor records slave-select edges, begin pulses and sent bytes, and
// compares them with what the framing rules predict: byte table, setup and
// hold spacing, chaining rate, poll gap, sample assembly, status flags.
// ---------------------------------------------------------------------------
module tb_gyro_spi_sequencer;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int POLL  = 50;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  spi_recieved_data;
  logic        spi_end_transmission;
  logic [7:0]  spi_send_data;
  logic        spi_begin_transmission;
  logic        spi_slave_select;
  logic [15:0] x_axis, y_axis, z_axis;
  logic        data_valid, cfg_done, timeout_err, busy;

  gyro_spi_sequencer #(
    .CTRL_REG1_VAL   (8'h0F),
    .CTRL_REG4_VAL   (8'h30),
    .SS_SETUP_CYCLES (16'(SETUP)),
    .SS_HOLD_CYCLES  (16'(HOLD)),
    .POLL_CYCLES     (24'(POLL)),
    .TIMEOUT_CYCLES  (24'(TMO))
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable                 (enable),
    .spi_recieved_data      (spi_recieved_data),
    .spi_end_transmission   (spi_end_transmission),
    .spi_send_data          (spi_send_data),
    .spi_begin_transmission (spi_begin_transmission),
    .spi_slave_select       (spi_slave_select),
    .x_axis                 (x_axis),
    .y_axis                 (y_axis),
    .z_axis                 (z_axis),
    .data_valid             (data_valid),
    .cfg_done               (cfg_done),
    .timeout_err            (timeout_err),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected byte i of a frame of the given kind (0: REG1, 1: REG4, 2: read).
  function automatic logic [7:0] exp_byte(input int kind, input int i);
    if (kind == 0) return (i == 0) ? 8'h20 : 8'h0F;
    if (kind == 1) return (i == 0) ? 8'h23 : 8'h30;
    return (i == 0) ? 8'hE8 : 8'h00;
  endfunction

  // Reference model of the published state.
  logic [15:0] mdl_x, mdl_y, mdl_z;
  logic        mdl_cfg, mdl_tmo;
  int          last_rise = 0;
  int          next_gap  = -1;

  // Engine model state and per-frame logs.
  logic [7:0] resp_plan[$];
  logic [7:0] rx_log[$];
  int         bt_log[$];
  int         end_log[$];
  int         eng_cnt  = 0;
  int         eng_mute = -1;
  int         e_bt;
  logic [7:0] e_rsp;

  // Engine: latches begin at the clock edge, is busy for e_bt cycles, then
  // pulses end_transmission for one cycle with its response byte.
  initial begin
    spi_end_transmission = 1'b0;
    spi_recieved_data    = 8'h00;
    forever begin
      @(negedge clk);
      spi_end_transmission = 1'b0;
      if (spi_begin_transmission && rst) begin
        eng_cnt++;
        if (eng_cnt - 1 != eng_mute) begin
          e_bt = int'($urandom_range(5, 1));
          if (resp_plan.size() > 0) e_rsp = resp_plan.pop_front();
          else                      e_rsp = 8'($urandom);
          repeat (e_bt + 1) @(negedge clk);
          spi_recieved_data    = e_rsp;
          spi_end_transmission = 1'b1;
          rx_log.push_back(e_rsp);
          bt_log.push_back(e_bt);
          end_log.push_back(cyc);
        end
      end
    end
  end

  // Observe one slave-select frame and check it against the rules.
  // mute_idx >= 0: engine ignores that byte (watchdog expected).
  // drop_idx >= 0: enable is dropped when that byte's begin is seen.
  // exp_gap  >= 0: required cycles from the previous SS rise to this fall.
  task automatic run_frame(input int kind, input int mute_idx, input int drop_idx,
                           input int exp_gap);
    int         f, r, nb, n_exp, bad_busy, dv_early;
    int         b_cyc[$];
    logic [7:0] sent[$];
    bit         found, tmo;

    rx_log.delete();
    bt_log.delete();
    end_log.delete();
    eng_cnt  = 0;
    eng_mute = mute_idx;
    tmo      = (mute_idx >= 0);

    found = 1'b0;
    for (int n = 0; n < POLL + 200; n++) begin
      @(negedge clk);
      if (!spi_slave_select) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check("ss_fall_timeout", 64'(spi_slave_select), 64'(0));
      return;
    end
    f = cyc;
    if (exp_gap >= 0) check("frame_gap", 64'(f - last_rise), 64'(exp_gap));
    check("xyz_held", {16'h0, x_axis, y_axis, z_axis}, {16'h0, mdl_x, mdl_y, mdl_z});

    found    = 1'b0;
    bad_busy = 0;
    dv_early = 0;
    for (int n = 0; n < 2000; n++) begin
      if (spi_slave_select) begin
        found = 1'b1;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (data_valid)    dv_early++;
      if (spi_begin_transmission) begin
        b_cyc.push_back(cyc);
        sent.push_back(spi_send_data);
        if (b_cyc.size() == drop_idx + 1) enable = 1'b0;
      end
      @(negedge clk);
    end
    if (!found) begin
      check("ss_rise_timeout", 64'(spi_slave_select), 64'(1));
      return;
    end
    r  = cyc;
    nb = b_cyc.size();

    n_exp = tmo ? mute_idx + 1 : ((kind == 2) ? 7 : 2);
    check("n_begin", 64'(nb), 64'(n_exp));
    if (nb > 0) check("ss_setup", 64'(b_cyc[0] - f), 64'(SETUP));
    for (int i = 0; i < nb && i < n_exp; i++)
      check($sformatf("byte%0d_k%0d", i, kind), 64'(sent[i]), 64'(exp_byte(kind, i)));
    for (int i = 1; i < nb && i - 1 < bt_log.size(); i++)
      check("byte_spacing", 64'(b_cyc[i] - b_cyc[i-1]), 64'(bt_log[i-1] + 2));
    check("busy_in_frame", 64'(bad_busy), 64'(0));
    check("dv_in_frame", 64'(dv_early), 64'(0));
    check("busy_after", 64'(busy), 64'(0));

    if (tmo) begin
      if (nb > 0) check("watchdog", 64'(r - b_cyc[nb-1]), 64'(TMO));
      mdl_tmo = 1'b1;
      mdl_cfg = 1'b0;
      check("dv_on_timeout", 64'(data_valid), 64'(0));
      next_gap = POLL + 1;
    end else begin
      if (end_log.size() > 0)
        check("ss_hold", 64'(r - end_log[end_log.size()-1]), 64'(HOLD));
      if (kind == 2) begin
        if (rx_log.size() == 7) begin
          mdl_x = {rx_log[2], rx_log[1]};
          mdl_y = {rx_log[4], rx_log[3]};
          mdl_z = {rx_log[6], rx_log[5]};
        end
        check("dv_at_rise", 64'(data_valid), 64'(1));
        next_gap = POLL + 1;
      end else begin
        check("dv_cfg", 64'(data_valid), 64'(0));
        if (kind == 1) mdl_cfg = 1'b1;
        next_gap = 2;
      end
    end
    check("xyz", {16'h0, x_axis, y_axis, z_axis}, {16'h0, mdl_x, mdl_y, mdl_z});
    check("cfg_done", 64'(cfg_done), 64'(mdl_cfg));
    check("timeout_err", 64'(timeout_err), 64'(mdl_tmo));
    last_rise = r;
    @(negedge clk);
    check("dv_width", 64'(data_valid), 64'(0));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ss"},    64'(spi_slave_select), 64'(1));
    check({pfx, "_busy"},  64'(busy), 64'(0));
    check({pfx, "_begin"}, 64'(spi_begin_transmission), 64'(0));
    check({pfx, "_send"},  64'(spi_send_data), 64'(0));
    check({pfx, "_xyz"},   {16'h0, x_axis, y_axis, z_axis}, 64'(0));
    check({pfx, "_flags"}, 64'({data_valid, cfg_done, timeout_err}), 64'(0));
  endtask

  task automatic model_reset();
    mdl_x   = '0;
    mdl_y   = '0;
    mdl_z   = '0;
    mdl_cfg = 1'b0;
    mdl_tmo = 1'b0;
  endtask

  initial begin
    int  bad;
    bit  found;

    rst    = 1'b0;
    enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Configuration, then the directed read frame.
    run_frame(0, -1, -1, -1);
    run_frame(1, -1, -1, next_gap);
    resp_plan = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    run_frame(2, -1, -1, next_gap);
    check("x_directed", 64'(x_axis), 64'(16'h1234));
    check("y_directed", 64'(y_axis), 64'(16'h5678));
    check("z_directed", 64'(z_axis), 64'(16'h9ABC));

    // Random read frames at the poll rate.
    repeat (4) run_frame(2, -1, -1, next_gap);

    // Silent engine on a random byte: watchdog, then reconfiguration.
    run_frame(2, int'($urandom_range(6, 0)), -1, next_gap);
    run_frame(0, -1, -1, next_gap);
    run_frame(1, -1, -1, next_gap);
    run_frame(2, -1, -1, next_gap);

    // enable dropped during byte 3: frame completes, then the block idles.
    run_frame(2, -1, 3, next_gap);
    bad = 0;
    repeat (POLL + 30) begin
      @(negedge clk);
      if (spi_slave_select !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_after_disable", 64'(bad), 64'(0));

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!spi_slave_select) begin
        found = 1'b1;
        break;
      end
    end
    check("pre_reset_frame", 64'(found), 64'(1));
    repeat (6) @(negedge clk);
    check("pre_reset_ss", 64'(spi_slave_select), 64'(0));
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    run_frame(0, -1, -1, -1);
    run_frame(1, -1, -1, next_gap);
    run_frame(2, -1, -1, next_gap);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gyro_spi_sequencer.md
Name: gyro_spi_sequencer

Overview:
Sequences the 8-bit SPI byte engine (send_data/begin_transmission/slave_select in; recieved_data/end_transmission out) to run the 3-axis gyro. After reset it writes two configuration registers, then periodically burst-reads OUT_X_L..OUT_Z_H (0x28..0x2D) and presents signed 16-bit X/Y/Z samples with a one-cycle valid strobe. It owns slave_select framing, byte chaining and a per-byte watchdog.

Parameters:
CTRL_REG1_VAL, 8'h0F, value written to register 0x20 (power on, XYZ enabled)
CTRL_REG4_VAL, 8'h30, value written to register 0x23 (full-scale select)
SS_SETUP_CYCLES, 16'd100, clk cycles from SS low to first begin pulse
SS_HOLD_CYCLES, 16'd100, clk cycles from last end_transmission to SS high
POLL_CYCLES, 24'd1000000, clk cycles from SS high to start of next read frame
TIMEOUT_CYCLES, 24'd200000, max clk cycles waiting for one end_transmission

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
enable  in  1  level; 0 holds sequencer in IDLE between frames
spi_recieved_data  in  8  byte returned by engine
spi_end_transmission  in  1  engine one-cycle byte-done pulse
spi_send_data  out  8  byte to engine
spi_begin_transmission  out  1  one-cycle start pulse to engine
spi_slave_select  out  1  chip select to engine/device, active-low
x_axis  out  16  last X sample {OUT_X_H, OUT_X_L}
y_axis  out  16  last Y sample
z_axis  out  16  last Z sample
data_valid  out  1  one-cycle pulse when x/y/z updated together
cfg_done  out  1  level; both config writes completed since reset/error
timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset
busy  out  1  1 whenever spi_slave_select is 0

Behaviour:
- Reset (rst=0, async): state IDLE; spi_slave_select=1; spi_begin_transmission=0; spi_send_data=8'h00; x/y/z=16'h0000; data_valid=0; cfg_done=0; timeout_err=0; txn index=0; all counters 0.
- Transactions (txn): 0 = {8'h20, CTRL_REG1_VAL}; 1 = {8'h23, CTRL_REG4_VAL}; 2 = {8'hE8 (read|auto-inc|0x28), 6 x 8'h00}. After txn 1 completes cfg_done=1 and txn stays 2 forever.
- States: IDLE, SS_SETUP, SEND, WAIT_DONE, SS_HOLD, POLL_WAIT.
- IDLE: SS=1. If enable=1 -> SS_SETUP next cycle, SS driven 0, byte index=0, counter cleared.
- SS_SETUP: count SS_SETUP_CYCLES, then SEND.
- SEND (exactly one cycle): spi_send_data=table byte; spi_begin_transmission=1; -> WAIT_DONE; watchdog cleared. spi_send_data held stable until next SEND.
- WAIT_DONE: on spi_end_transmission=1: for txn 2, bytes 1..6 latched into X_L,X_H,Y_L,Y_H,Z_L,Z_H shadow regs in the same cycle (byte 0 response discarded; config responses discarded). If more bytes remain -> SEND next cycle (SS stays 0, engine chains from hold). Else -> SS_HOLD.
- Byte timing: begin pulse to next begin pulse = engine byte time + 2 clk.
- SS_HOLD: count SS_HOLD_CYCLES, then SS=1; if txn was 2, copy shadows to x/y/z and pulse data_valid in the cycle SS rises; -> POLL_WAIT (txn 0/1 advance index and go to POLL_WAIT with count forced to 0-length, i.e. next cycle IDLE-check).
- POLL_WAIT: SS=1, count POLL_CYCLES then -> IDLE. Config transactions skip the poll wait (min 1 cycle SS high).
- enable is sampled only in IDLE; deasserting mid-frame completes the frame.
- Watchdog: in WAIT_DONE, if TIMEOUT_CYCLES elapse without end_transmission: SS=1, timeout_err=1, cfg_done=0, txn=0, shadows discarded, no data_valid, -> POLL_WAIT (full POLL_CYCLES) then restart config.
- end_transmission outside WAIT_DONE is ignored.
- x/y/z update atomically; never partially updated frame visible.
- Counters saturate-free: compare with ==, wrap to 0 on state change; widths 16/24 bits as parameters.

Test Plan:
- Reset with rst=0 mid-frame (SS=0) -> SS=1, all outputs 0 immediately (asynchronous), restart from txn 0 after rst=1.
- enable=1, engine model echoing; SS_SETUP=4, SS_HOLD=4 -> bytes 8'h20,8'h0F then 8'h23,8'h30 sent in two separate SS frames; cfg_done=1 after second SS rise.
- Read frame, device returns 0x34,0x12,0x78,0x56,0xBC,0x9A on bytes 1..6 -> x=16'h1234, y=16'h5678, z=16'h9ABC, one data_valid pulse coincident with SS rise; 7 begin pulses in frame.
- POLL_CYCLES=50 -> consecutive read frames start exactly 50 cycles + 1 after SS rise; values held between frames.
- Engine model withholds end_transmission, TIMEOUT=20 -> SS high 20 cycles after begin, timeout_err=1, cfg_done=0, next frame is 8'h20 write.
- enable dropped during byte 3 of read -> frame finishes with data_valid; sequencer then stays IDLE with SS=1, busy=0.
